// File: rtl/kbd_fifo_if.sv
// Keyboard FIFO bus: key-push side from the PS/2 controller plus the CPU
// data/status read side. The master drives the inputs; the FIFO is the slave.
interface kbd_fifo_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_W-1:0] wr_data;
  logic              wr_strb;
  logic              kbd_clr;
  logic              ovf_clr;
  logic [DATA_W-1:0] kbd;
  logic [7:0]        kbd_strb;
  logic [AW:0]       count;

  modport master (
    output wr_data, wr_strb, kbd_clr, ovf_clr,
    input  kbd, kbd_strb, count
  );

  modport slave (
    input  wr_data, wr_strb, kbd_clr, ovf_clr,
    output kbd, kbd_strb, count
  );
endinterface

// File: rtl/kbd_fifo.sv
// Keyboard receive FIFO between the PS/2 controller and the CPU read path.
// Queues key codes, exposes an Apple-1 style data/status pair, tracks overflow.
module kbd_fifo #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned HI_BIT     = 1,
  parameter int unsigned OVF_POLICY = 0
) (
  input logic        clock_50,
  input logic        res,
  kbd_fifo_if.slave  bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCnt = (AW + 1)'(DEPTH);
  localparam logic [DATA_W-1:0] HiMask =
    (HI_BIT != 0) ? {1'b1, {(DATA_W - 1){1'b0}}} : '0;
  localparam logic Overwrite = (OVF_POLICY != 0);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_rd_ptr, r_wr_ptr;
  logic [AW:0]       r_count;
  logic              r_ovf;
  logic              r_clr_q;

  logic [AW-1:0]     w_rd_ptr_d, w_wr_ptr_d;
  logic [AW:0]       w_count_d;
  logic              w_ovf_d;
  logic              w_full, w_empty;
  logic              w_pop_req, w_pop;
  logic              w_wr_en, w_ovf_set, w_rd_adv;
  logic              w_inc, w_dec;
  logic              w_avail;

  // One CPU read may hold kbd_clr for many cycles; only its rising edge pops.
  assign w_pop_req = bus.kbd_clr & ~r_clr_q;
  assign w_full    = (r_count == FullCnt);
  assign w_empty   = (r_count == '0);
  assign w_pop     = w_pop_req & ~w_empty;

  // A simultaneous pop frees a slot, so a push into a full FIFO is not an overflow.
  assign w_ovf_set = bus.wr_strb & w_full & ~w_pop;
  assign w_wr_en   = bus.wr_strb & (~w_full | w_pop | Overwrite);
  assign w_rd_adv  = w_pop | (w_ovf_set & Overwrite);
  assign w_inc     = w_wr_en & ~w_pop & ~w_full;
  assign w_dec     = w_pop & ~w_wr_en;

  always_comb begin
    w_rd_ptr_d = r_rd_ptr;
    w_wr_ptr_d = r_wr_ptr;
    w_count_d  = r_count;
    w_ovf_d    = r_ovf;
    if (w_wr_en) begin
      w_wr_ptr_d = r_wr_ptr + AW'(1);
    end
    if (w_rd_adv) begin
      w_rd_ptr_d = r_rd_ptr + AW'(1);
    end
    if (w_inc) begin
      w_count_d = r_count + (AW + 1)'(1);
    end else if (w_dec) begin
      w_count_d = r_count - (AW + 1)'(1);
    end
    // Set wins over a same-cycle clear.
    if (w_ovf_set) begin
      w_ovf_d = 1'b1;
    end else if (bus.ovf_clr) begin
      w_ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clock_50) begin
    if (res) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_clr_q  <= 1'b1;
    end else begin
      r_rd_ptr <= w_rd_ptr_d;
      r_wr_ptr <= w_wr_ptr_d;
      r_count  <= w_count_d;
      r_ovf    <= w_ovf_d;
      r_clr_q  <= bus.kbd_clr;
    end
  end

  // Storage is deliberately not cleared by reset; avail masks stale contents.
  always_ff @(posedge clock_50) begin
    if (w_wr_en && !res) begin
      r_mem[r_wr_ptr] <= bus.wr_data;
    end
  end

  assign w_avail      = ~w_empty;
  assign bus.kbd      = w_avail ? (r_mem[r_rd_ptr] | HiMask) : '0;
  assign bus.kbd_strb = {w_avail, r_ovf, 6'b000000};
  assign bus.count    = r_count;
endmodule

// File: tb/tb_kbd_fifo.sv
// Bench for kbd_fifo: drop-newest and overwrite-oldest instances share one
// stimulus stream and are compared against queue-based reference models.
module tb_kbd_fifo;
  localparam int unsigned Depth = 16;

  logic       clk = 1'b0;
  logic       res = 1'b1;
  logic [7:0] wr_data = 8'h00;
  logic       wr_strb = 1'b0;
  logic       kbd_clr = 1'b0;
  logic       ovf_clr = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  kbd_fifo_if #(.DATA_W(8), .DEPTH(Depth)) bus0 ();
  kbd_fifo_if #(.DATA_W(8), .DEPTH(Depth)) bus1 ();

  assign bus0.wr_data = wr_data;
  assign bus0.wr_strb = wr_strb;
  assign bus0.kbd_clr = kbd_clr;
  assign bus0.ovf_clr = ovf_clr;
  assign bus1.wr_data = wr_data;
  assign bus1.wr_strb = wr_strb;
  assign bus1.kbd_clr = kbd_clr;
  assign bus1.ovf_clr = ovf_clr;

  kbd_fifo #(.DATA_W(8), .DEPTH(Depth), .HI_BIT(1), .OVF_POLICY(0)) u_dut0 (
    .clock_50 (clk),
    .res      (res),
    .bus      (bus0)
  );

  kbd_fifo #(.DATA_W(8), .DEPTH(Depth), .HI_BIT(1), .OVF_POLICY(1)) u_dut1 (
    .clock_50 (clk),
    .res      (res),
    .bus      (bus1)
  );

  logic [7:0] kbd_o  [2];
  logic [7:0] strb_o [2];
  logic [4:0] cnt_o  [2];
  assign kbd_o[0]  = bus0.kbd;
  assign kbd_o[1]  = bus1.kbd;
  assign strb_o[0] = bus0.kbd_strb;
  assign strb_o[1] = bus1.kbd_strb;
  assign cnt_o[0]  = bus0.count;
  assign cnt_o[1]  = bus1.count;

  // Reference model: index 0 drops newest on overflow, index 1 overwrites oldest.
  logic [7:0] mq0[$];
  logic [7:0] mq1[$];
  logic       movf [2];
  logic       mclr_prev;

  function automatic int qsize(input int p);
    return (p == 0) ? mq0.size() : mq1.size();
  endfunction

  function automatic void qpush(input int p, input logic [7:0] d);
    if (p == 0) mq0.push_back(d);
    else mq1.push_back(d);
  endfunction

  function automatic void qpop(input int p);
    logic [7:0] tmp;
    if (p == 0) tmp = mq0.pop_front();
    else tmp = mq1.pop_front();
  endfunction

  function automatic logic [7:0] exp_kbd(input int p);
    if (qsize(p) == 0) return 8'h00;
    return ((p == 0) ? mq0[0] : mq1[0]) | 8'h80;
  endfunction

  function automatic logic [7:0] exp_strb(input int p);
    return {qsize(p) != 0, movf[p], 6'b000000};
  endfunction

  function automatic logic [4:0] exp_cnt(input int p);
    return 5'(qsize(p));
  endfunction

  function automatic void model_update(input logic r, input logic ws, input logic [7:0] d,
                                       input logic kc, input logic oc);
    logic pop_req, full, pop;
    if (r) begin
      mq0.delete();
      mq1.delete();
      movf[0]   = 1'b0;
      movf[1]   = 1'b0;
      mclr_prev = 1'b1;
      return;
    end
    pop_req = kc & ~mclr_prev;
    for (int p = 0; p < 2; p++) begin
      full = (qsize(p) == Depth);
      pop  = pop_req && (qsize(p) > 0);
      if (ws) begin
        if (!full || pop) begin
          if (pop) qpop(p);
          qpush(p, d);
        end else if (p == 1) begin
          qpop(p);
          qpush(p, d);
        end
      end else if (pop) begin
        qpop(p);
      end
      if (ws && full && !pop) movf[p] = 1'b1;
      else if (oc) movf[p] = 1'b0;
    end
    mclr_prev = kc;
  endfunction

  // Apply one cycle of inputs, advance the model, sample #1 after the edge.
  task automatic step(input logic r, input logic ws, input logic [7:0] d,
                      input logic kc, input logic oc);
    res     = r;
    wr_strb = ws;
    wr_data = d;
    kbd_clr = kc;
    ovf_clr = oc;
    @(posedge clk);
    model_update(r, ws, d, kc, oc);
    #1;
  endtask

  task automatic test_reset;
    step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    for (int p = 0; p < 2; p++) begin
      n_vec++;
      if (kbd_o[p] !== 8'h00 || strb_o[p] !== 8'h00 || cnt_o[p] !== 5'd0) begin
        n_err++;
        $display("FAIL reset[p%0d]: got kbd=%h strb=%h cnt=%0d, want 00 00 0",
                 p, kbd_o[p], strb_o[p], cnt_o[p]);
      end
    end
    // kbd_clr still high from reset: a push must not be popped
    step(1'b0, 1'b1, 8'h41, 1'b1, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    for (int p = 0; p < 2; p++) begin
      n_vec++;
      if (kbd_o[p] !== 8'hC1 || cnt_o[p] !== 5'd1 || cnt_o[p] !== exp_cnt(p)) begin
        n_err++;
        $display("FAIL reset_no_pop[p%0d]: got kbd=%h cnt=%0d, want C1 1",
                 p, kbd_o[p], cnt_o[p]);
      end
    end
  endtask

  task automatic test_order;
    logic [7:0] want_kbd [3];
    want_kbd[0] = 8'hC2;
    want_kbd[1] = 8'hC3;
    want_kbd[2] = 8'h00;
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h41, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h42, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h43, 1'b0, 1'b0);
    n_vec++;
    if (kbd_o[0] !== 8'hC1 || cnt_o[0] !== 5'd3) begin
      n_err++;
      $display("FAIL order_fill: got kbd=%h cnt=%0d, want C1 3", kbd_o[0], cnt_o[0]);
    end
    for (int i = 0; i < 3; i++) begin
      for (int c = 0; c < 5; c++) begin
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        for (int p = 0; p < 2; p++) begin
          n_vec++;
          if (kbd_o[p] !== want_kbd[i] || cnt_o[p] !== 5'(2 - i) ||
              kbd_o[p] !== exp_kbd(p)) begin
            n_err++;
            $display("FAIL order_read%0d[p%0d]: got kbd=%h cnt=%0d, want %h %0d",
                     i, p, kbd_o[p], cnt_o[p], want_kbd[i], 2 - i);
          end
        end
      end
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    end
  endtask

  task automatic test_overflow;
    logic [7:0] want_head [2];
    logic [7:0] want_last [2];
    logic [7:0] last [2];
    want_head[0] = 8'h81;
    want_head[1] = 8'h82;
    want_last[0] = 8'h90;
    want_last[1] = 8'h91;
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int k = 1; k <= 17; k++) step(1'b0, 1'b1, 8'(k), 1'b0, 1'b0);
    for (int p = 0; p < 2; p++) begin
      n_vec++;
      if (cnt_o[p] !== 5'd16 || strb_o[p] !== 8'hC0 || kbd_o[p] !== want_head[p]) begin
        n_err++;
        $display("FAIL ovf_full[p%0d]: got cnt=%0d strb=%h kbd=%h, want 16 C0 %h",
                 p, cnt_o[p], strb_o[p], kbd_o[p], want_head[p]);
      end
    end
    last[0] = 8'h00;
    last[1] = 8'h00;
    for (int i = 0; i < 16; i++) begin
      for (int p = 0; p < 2; p++) if (cnt_o[p] == 5'd1) last[p] = kbd_o[p];
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      for (int p = 0; p < 2; p++) begin
        n_vec++;
        if (kbd_o[p] !== exp_kbd(p) || strb_o[p] !== exp_strb(p) ||
            cnt_o[p] !== exp_cnt(p)) begin
          n_err++;
          $display("FAIL ovf_drain%0d[p%0d]: got kbd=%h strb=%h cnt=%0d, want %h %h %0d",
                   i, p, kbd_o[p], strb_o[p], cnt_o[p], exp_kbd(p), exp_strb(p), exp_cnt(p));
        end
      end
    end
    for (int p = 0; p < 2; p++) begin
      n_vec++;
      if (last[p] !== want_last[p]) begin
        n_err++;
        $display("FAIL ovf_last[p%0d]: got %h, want %h", p, last[p], want_last[p]);
      end
    end
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int p = 0; p < 2; p++) begin
      n_vec++;
      if (strb_o[p] !== 8'h00) begin
        n_err++;
        $display("FAIL ovf_clr[p%0d]: got strb=%h, want 00", p, strb_o[p]);
      end
    end
  endtask

  task automatic test_full_push_pop;
    logic [7:0] second, newkey;
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    second = 8'h00;
    for (int k = 0; k < 16; k++) begin
      wr_data = 8'($urandom);
      if (k == 1) second = wr_data;
      step(1'b0, 1'b1, wr_data, 1'b0, 1'b0);
    end
    newkey = 8'($urandom);
    step(1'b0, 1'b1, newkey, 1'b1, 1'b0);
    for (int p = 0; p < 2; p++) begin
      n_vec++;
      if (cnt_o[p] !== 5'd16 || strb_o[p] !== 8'h80 || kbd_o[p] !== (second | 8'h80)) begin
        n_err++;
        $display("FAIL full_pp[p%0d]: got cnt=%0d strb=%h kbd=%h, want 16 80 %h",
                 p, cnt_o[p], strb_o[p], kbd_o[p], second | 8'h80);
      end
    end
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    end
    for (int p = 0; p < 2; p++) begin
      n_vec++;
      if (cnt_o[p] !== 5'd1 || kbd_o[p] !== (newkey | 8'h80)) begin
        n_err++;
        $display("FAIL full_pp_tail[p%0d]: got cnt=%0d kbd=%h, want 1 %h",
                 p, cnt_o[p], kbd_o[p], newkey | 8'h80);
      end
    end
  endtask

  task automatic test_empty_push_pop;
    logic [7:0] key;
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    key = 8'($urandom);
    step(1'b0, 1'b1, key, 1'b1, 1'b0);
    for (int p = 0; p < 2; p++) begin
      n_vec++;
      if (cnt_o[p] !== 5'd1 || kbd_o[p] !== (key | 8'h80)) begin
        n_err++;
        $display("FAIL empty_pp[p%0d]: got cnt=%0d kbd=%h, want 1 %h",
                 p, cnt_o[p], kbd_o[p], key | 8'h80);
      end
    end
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 8'($urandom), 1'b0, 1'b0);
    for (int p = 0; p < 2; p++) begin
      n_vec++;
      if (cnt_o[p] !== 5'd5) begin
        n_err++;
        $display("FAIL pre_reset_cnt[p%0d]: got %0d, want 5", p, cnt_o[p]);
      end
    end
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int p = 0; p < 2; p++) begin
      n_vec++;
      if (cnt_o[p] !== 5'd0 || strb_o[p][7] !== 1'b0 || kbd_o[p] !== 8'h00) begin
        n_err++;
        $display("FAIL mid_reset[p%0d]: got cnt=%0d strb=%h kbd=%h, want 0 00 00",
                 p, cnt_o[p], strb_o[p], kbd_o[p]);
      end
    end
  endtask

  task automatic test_random;
    logic r, ws, kc, oc;
    kc = 1'b0;
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 800; i++) begin
      r  = ($urandom_range(0, 199) == 0);
      ws = ($urandom_range(0, 1) == 0);
      if ($urandom_range(0, 2) == 0) kc = ~kc;
      oc = ($urandom_range(0, 19) == 0);
      step(r, ws, 8'($urandom), kc, oc);
      for (int p = 0; p < 2; p++) begin
        n_vec++;
        if (kbd_o[p] !== exp_kbd(p) || strb_o[p] !== exp_strb(p) ||
            cnt_o[p] !== exp_cnt(p)) begin
          n_err++;
          $display("FAIL random%0d[p%0d]: got kbd=%h strb=%h cnt=%0d, want %h %h %0d",
                   i, p, kbd_o[p], strb_o[p], cnt_o[p], exp_kbd(p), exp_strb(p), exp_cnt(p));
        end
      end
    end
  endtask

  initial begin
    movf[0]   = 1'b0;
    movf[1]   = 1'b0;
    mclr_prev = 1'b1;
    test_reset();
    test_order();
    test_overflow();
    test_full_push_pop();
    test_empty_push_pop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
